jt12_pres_ctrl: RTL and testbench

// - CPU-side write sequencer for the FM core; owns the prescaler setting consumed by the clock divider.
// - Decodes prescaler address writes (0x2D/0x2E/0x2F) into div_setting.
// - Paces data writes to the register file with a busy window counted in divider clk_en pulses.
// - Enforces a settle window after every prescaler change.

---
 rtl/jt12_pres_ctrl.sv | 165 ++++++++++++++++
 tb/tb_jt12_pres_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_pres_ctrl.sv
// jt12_pres_ctrl: CPU-side write sequencer for the FM core.
// Latches register addresses, forwards data writes as one-clk pulses to the
// register file, owns the prescaler select (div_setting), and holds off
// further writes during a busy window (data writes) or a settle window
// (prescaler changes).
// Optional feature macro: JT12_PRES_OVERRUN_EN. When it is defined, a sticky
// overrun flag records writes rejected while busy. When it is undefined,
// overrun is tied low and ovr_clr is ignored.
module jt12_pres_ctrl #(
  parameter int         NUM_CH        = 3,
  parameter int         BUSY_CYCLES   = 32,
  parameter int         SETTLE_CYCLES = 8,
  parameter logic [1:0] DEFAULT_DIV   = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       clk_en,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       ovr_clr,
  output logic [1:0] div_setting,
  output logic       busy,
  output logic       wr_out,
  output logic [7:0] addr_out,
  output logic [7:0] dout,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, BUSY, SETTLE} state_t;

  // Six-channel parts have a fixed divider, so prescaler addresses are ordinary.
  localparam logic       PRES_EN     = (NUM_CH == 3);
  localparam logic [7:0] BUSY_LOAD   = 8'(BUSY_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;

  logic       addr_wr, data_wr, is_pres, pres_change, reject;
  logic [1:0] pres_val;

  logic [1:0] div_d;
  logic       busy_d, wr_out_d, ovr_d;
  logic [7:0] addr_d, dout_d;

  assign addr_wr = wr & ~a0;
  assign data_wr = wr & a0;
  assign is_pres = PRES_EN && (din inside {8'h2D, 8'h2E, 8'h2F});

  // Prescaler address to divider select.
  always_comb begin
    case (din)
      8'h2D:   pres_val = 2'b10;
      8'h2E:   pres_val = 2'b11;
      default: pres_val = 2'b00;
    endcase
  end

  // A repeated write of the current prescaler value needs no settle window.
  assign pres_change = addr_wr & is_pres & (pres_val != div_setting);
  // Writes that would disturb an open window are dropped and flagged.
  assign reject      = (state != IDLE) & (data_wr | (addr_wr & is_pres));

  // State register: FSM state and the shared window down-counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic: open windows from IDLE, count them down on their enable.
  // NOTE: defaults at the top of the block keep every path assigned, so no
  // latches are inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (data_wr) begin
          state_d = BUSY;
          cnt_d   = BUSY_LOAD;
        end else if (pres_change) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      BUSY: begin
        if (clk_en) begin
          if (cnt == 8'd0) state_d = IDLE;
          else             cnt_d   = cnt - 8'd1;
        end
      end
      SETTLE: begin
        if (cen) begin
          if (cnt == 8'd0) state_d = IDLE;
          else             cnt_d   = cnt - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    div_d    = div_setting;
    wr_out_d = 1'b0;
    addr_d   = addr_out;
    dout_d   = dout;
    busy_d   = (state_d != IDLE);
    // Address latching is never paced, even inside a window.
    if (addr_wr) addr_d = din;
    if (state == IDLE) begin
      if (data_wr) begin
        wr_out_d = 1'b1;
        dout_d   = din;
      end else if (pres_change) begin
        div_d = pres_val;
      end
    end
`ifdef JT12_PRES_OVERRUN_EN
    // Set has priority over clear so a rejection is never lost.
    ovr_d = overrun;
    if (ovr_clr) ovr_d = 1'b0;
    if (reject)  ovr_d = 1'b1;
`else
    ovr_d = 1'b0;
`endif
  end

`ifndef JT12_PRES_OVERRUN_EN
  logic unused_ovr;
  assign unused_ovr = ovr_clr | reject;
`endif

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_setting <= DEFAULT_DIV;
      busy        <= 1'b0;
      wr_out      <= 1'b0;
      addr_out    <= 8'd0;
      dout        <= 8'd0;
      overrun     <= 1'b0;
    end else begin
      div_setting <= div_d;
      busy        <= busy_d;
      wr_out      <= wr_out_d;
      addr_out    <= addr_d;
      dout        <= dout_d;
      overrun     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_jt12_pres_ctrl.sv
// Directed testbench for jt12_pres_ctrl: a three-channel instance and a
// six-channel instance driven by the same stimulus.
module tb_jt12_pres_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b0;
  logic       clk_en = 1'b0;
  logic       wr = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'd0;
  logic       ovr_clr = 1'b0;

  logic [1:0] div_setting, div_setting6;
  logic       busy, busy6, wr_out, wr_out6, overrun, overrun6;
  logic [7:0] addr_out, addr_out6, dout, dout6;

  int compared = 0;
  int mismatched = 0;

`ifdef JT12_PRES_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  jt12_pres_ctrl #(.NUM_CH(3)) u_dut (
    .clk(clk), .rst(rst), .cen(cen), .clk_en(clk_en), .wr(wr), .a0(a0),
    .din(din), .ovr_clr(ovr_clr), .div_setting(div_setting), .busy(busy),
    .wr_out(wr_out), .addr_out(addr_out), .dout(dout), .overrun(overrun)
  );

  jt12_pres_ctrl #(.NUM_CH(6)) u_dut6 (
    .clk(clk), .rst(rst), .cen(cen), .clk_en(clk_en), .wr(wr), .a0(a0),
    .din(din), .ovr_clr(ovr_clr), .div_setting(div_setting6), .busy(busy6),
    .wr_out(wr_out6), .addr_out(addr_out6), .dout(dout6), .overrun(overrun6)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr = 1'b0; a0 = 1'b0; din = 8'd0; ovr_clr = 1'b0; clk_en = 1'b0; cen = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-clk CPU write; returns after the edge that consumed it.
  task automatic cpu_write(input logic is_data, input logic [7:0] val);
    wr = 1'b1; a0 = is_data; din = val;
    tick();
    wr = 1'b0; a0 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) tick();
    compared++;
    if (div_setting !== 2'b10) begin
      $display("FAIL reset_div: got %b want 10", div_setting); mismatched++;
    end
    compared++;
    if (busy !== 1'b0 || wr_out !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL reset_flags: busy=%b wr_out=%b overrun=%b want 0/0/0",
               busy, wr_out, overrun); mismatched++;
    end
    compared++;
    if (addr_out !== 8'h00 || dout !== 8'h00) begin
      $display("FAIL reset_regs: addr=%h dout=%h want 00/00", addr_out, dout); mismatched++;
    end
  endtask

  task automatic test_data_write();
    do_reset();
    cen = 1'b1;  // cen alone must not shorten the busy window
    cpu_write(1'b0, 8'h28);
    compared++;
    if (addr_out !== 8'h28 || busy !== 1'b0) begin
      $display("FAIL addr_latch: addr=%h busy=%b want 28/0", addr_out, busy); mismatched++;
    end
    cpu_write(1'b1, 8'hF0);
    compared++;
    if (wr_out !== 1'b1 || dout !== 8'hF0 || addr_out !== 8'h28 || busy !== 1'b1) begin
      $display("FAIL data_wr: wr_out=%b dout=%h addr=%h busy=%b want 1/f0/28/1",
               wr_out, dout, addr_out, busy); mismatched++;
    end
    // Every 6th clk carries a clk_en pulse.
    for (int p = 1; p <= 32; p++) begin
      repeat (5) tick();
      if (p == 1) begin
        compared++;
        if (wr_out !== 1'b0) begin
          $display("FAIL wr_out_width: got %b want 0", wr_out); mismatched++;
        end
      end
      clk_en = 1'b1;
      tick();
      clk_en = 1'b0;
      if (p == 31) begin
        compared++;
        if (busy !== 1'b1) begin
          $display("FAIL busy_pulse31: got %b want 1", busy); mismatched++;
        end
      end
    end
    compared++;
    if (busy !== 1'b0) begin
      $display("FAIL busy_pulse32: got %b want 0", busy); mismatched++;
    end
    cen = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    cpu_write(1'b1, 8'hF0);  // BUSY, cnt=31
    cpu_write(1'b1, 8'h55);
    compared++;
    if (wr_out !== 1'b0 || dout !== 8'hF0 || overrun !== OVR_EXP || busy !== 1'b1) begin
      $display("FAIL reject_data: wr_out=%b dout=%h ovr=%b busy=%b want 0/f0/%b/1",
               wr_out, dout, overrun, busy, OVR_EXP); mismatched++;
    end
    ovr_clr = 1'b1;
    cpu_write(1'b1, 8'h66);
    ovr_clr = 1'b0;
    compared++;
    if (overrun !== OVR_EXP || dout !== 8'hF0) begin
      $display("FAIL ovr_set_wins: ovr=%b dout=%h want %b/f0", overrun, dout, OVR_EXP);
      mismatched++;
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    compared++;
    if (overrun !== 1'b0) begin
      $display("FAIL ovr_clear: got %b want 0", overrun); mismatched++;
    end
    cpu_write(1'b0, 8'h2D);  // prescaler address while busy: latched, rejected
    compared++;
    if (addr_out !== 8'h2D || div_setting !== 2'b10 || overrun !== OVR_EXP) begin
      $display("FAIL reject_pres: addr=%h div=%b ovr=%b want 2d/10/%b",
               addr_out, div_setting, overrun, OVR_EXP); mismatched++;
    end
    // No clk_en yet: 31 pulses take cnt 31 -> 0, exit pulse comes with a write.
    clk_en = 1'b1;
    repeat (31) tick();
    compared++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_at_cnt0: got %b want 1", busy); mismatched++;
    end
    cpu_write(1'b1, 8'h77);
    clk_en = 1'b0;
    compared++;
    if (busy !== 1'b0 || wr_out !== 1'b0 || dout !== 8'hF0) begin
      $display("FAIL exit_cycle_reject: busy=%b wr_out=%b dout=%h want 0/0/f0",
               busy, wr_out, dout); mismatched++;
    end
    cpu_write(1'b1, 8'h77);
    compared++;
    if (wr_out !== 1'b1 || dout !== 8'h77) begin
      $display("FAIL after_exit_write: wr_out=%b dout=%h want 1/77", wr_out, dout);
      mismatched++;
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    cen = 1'b1;
    cpu_write(1'b0, 8'h2E);
    compared++;
    if (div_setting !== 2'b11 || busy !== 1'b1 || addr_out !== 8'h2E) begin
      $display("FAIL pres_change: div=%b busy=%b addr=%h want 11/1/2e",
               div_setting, busy, addr_out); mismatched++;
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      compared++;
      if (busy !== 1'b1) begin
        $display("FAIL settle_busy_%0d: got %b want 1", i, busy); mismatched++;
      end
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      $display("FAIL settle_end: got %b want 0", busy); mismatched++;
    end
    cpu_write(1'b0, 8'h2E);
    compared++;
    if (busy !== 1'b0 || div_setting !== 2'b11) begin
      $display("FAIL pres_repeat: busy=%b div=%b want 0/11", busy, div_setting);
      mismatched++;
    end
    cpu_write(1'b0, 8'h2F);
    compared++;
    if (div_setting !== 2'b00 || busy !== 1'b1) begin
      $display("FAIL pres_2f: div=%b busy=%b want 00/1", div_setting, busy); mismatched++;
    end
    cen = 1'b0;
  endtask

  task automatic test_num_ch6();
    do_reset();
    cpu_write(1'b0, 8'h2F);
    compared++;
    if (div_setting6 !== 2'b10 || addr_out6 !== 8'h2F || busy6 !== 1'b0) begin
      $display("FAIL ch6_pres_ignored: div=%b addr=%h busy=%b want 10/2f/0",
               div_setting6, addr_out6, busy6); mismatched++;
    end
    compared++;
    if (div_setting !== 2'b00 || busy !== 1'b1) begin
      $display("FAIL ch3_pres_2f: div=%b busy=%b want 00/1", div_setting, busy);
      mismatched++;
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    cen = 1'b1;
    cpu_write(1'b0, 8'h2E);  // SETTLE, cnt=7
    repeat (3) tick();       // cnt=4
    compared++;
    if (busy !== 1'b1 || div_setting !== 2'b11) begin
      $display("FAIL pre_rst_settle: busy=%b div=%b want 1/11", busy, div_setting);
      mismatched++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (busy !== 1'b0 || div_setting !== 2'b10) begin
      $display("FAIL rst_mid_settle: busy=%b div=%b want 0/10", busy, div_setting);
      mismatched++;
    end
    repeat (4) tick();
    compared++;
    if (busy !== 1'b0 || wr_out !== 1'b0) begin
      $display("FAIL rst_no_survivor: busy=%b wr_out=%b want 0/0", busy, wr_out);
      mismatched++;
    end
    cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_overrun();
    test_prescaler();
    test_num_ch6();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
